// File: rtl/spi_ctrl_pkg.sv
// Shared opcodes, field widths and FSM states for the host SPI control port.
package spi_ctrl_pkg;

   localparam int CMD_W = 8;
   localparam int IDX_W = 8;
   localparam int ERR_W = 7;

   localparam logic [CMD_W-1:0] CMD_READ_SAMPLES = 8'h01;
   localparam logic [CMD_W-1:0] CMD_WRITE_COEF   = 8'h02;
   localparam logic [CMD_W-1:0] CMD_READ_COEF    = 8'h03;
   localparam logic [CMD_W-1:0] CMD_STATUS       = 8'h04;

   typedef enum logic [2:0] {IDLE, CMD, INDEX, RX, TX, ERR, DONE} state_t;

endpackage

// File: rtl/spi_ctrl_port_if.sv
// Board-level SPI pins between the Raspberry Pi host and the control port.
interface spi_ctrl_port_if;
   logic SCLK;
   logic CS;
   logic MOSI;
   logic MISO;

   modport slave  (input SCLK, input CS, input MOSI, output MISO);
   modport master (output SCLK, output CS, output MOSI, input MISO);
endinterface

// File: rtl/spi_edge_sync.sv
// Multi-flop synchroniser for an asynchronous pin, with one-cycle rise/fall pulses.
module spi_edge_sync #(
   parameter int   STAGES  = 2,
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk_48,
   input  logic reset,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);

   logic [STAGES-1:0] sync_reg;
   logic              prev_reg;

   always_ff @(posedge clk_48) begin
      if (reset) begin
         sync_reg <= {STAGES{RST_VAL}};
         prev_reg <= RST_VAL;
      end else begin
         sync_reg <= {sync_reg[STAGES-2:0], din};
         prev_reg <= sync_reg[STAGES-1];
      end
   end

   assign sync = sync_reg[STAGES-1];
   assign rise = sync & ~prev_reg;
   assign fall = ~sync & prev_reg;

endmodule

// File: rtl/spi_ctrl_port.sv
// Mode-0 SPI slave: sample readback, coefficient bank read/write and a status byte,
// all oversampled in the clk_48 domain.
module spi_ctrl_port
   import spi_ctrl_pkg::*;
#(
   parameter int N_CH        = 2,
   parameter int SAMPLE_W    = 16,
   parameter int N_COEF      = 10,
   parameter int COEF_W      = 64,
   parameter int SYNC_STAGES = 2
) (
   input  logic                       clk_48,
   input  logic                       reset,
   spi_ctrl_port_if.slave             spi,
   input  logic                       sample_valid,
   input  logic [N_CH*SAMPLE_W-1:0]   samples_in,
   output logic [N_COEF*COEF_W-1:0]   coef_out,
   output logic                       coef_wr,
   output logic [$clog2(N_COEF)-1:0]  coef_wr_idx
);

   localparam int SMP_W = N_CH * SAMPLE_W;
   localparam int TX_W  = (SMP_W > COEF_W) ? SMP_W : COEF_W;
   localparam int CNT_W = $clog2(TX_W + 1);
   localparam int WI_W  = $clog2(N_COEF);

   logic sclk_level_unused, sclk_rise, sclk_fall;
   logic cs_sync, cs_rise, cs_fall;
   logic [SYNC_STAGES-1:0] mosi_sync_reg;
   logic mosi_sync;

   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
      .clk_48(clk_48), .reset(reset), .din(spi.SCLK),
      .sync(sclk_level_unused), .rise(sclk_rise), .fall(sclk_fall));

   // CS idles high, so its chain resets high to avoid a phantom frame start.
   spi_edge_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
      .clk_48(clk_48), .reset(reset), .din(spi.CS),
      .sync(cs_sync), .rise(cs_rise), .fall(cs_fall));

   always_ff @(posedge clk_48) begin
      if (reset) mosi_sync_reg <= '0;
      else       mosi_sync_reg <= {mosi_sync_reg[SYNC_STAGES-2:0], spi.MOSI};
   end
   assign mosi_sync = mosi_sync_reg[SYNC_STAGES-1];

   state_t             state_reg, state_next;
   logic [CNT_W-1:0]   cnt_reg, cnt_next, tx_last;
   logic [CMD_W-1:0]   cmd_reg, cmd_next, cmd_shift;
   logic [IDX_W-1:0]   idx_reg, idx_next, idx_shift;
   logic [COEF_W-1:0]  rx_reg, rx_next, coef_rd;
   logic [TX_W-1:0]    tx_reg, tx_next;
   logic [SMP_W-1:0]   hold_reg, hold_msb_first;
   logic [ERR_W-1:0]   err_reg;
   logic               miso_reg, miso_next, fresh_reg, fresh_next;
   logic               err_inc, coef_we, coef_wr_reg;
   logic [WI_W-1:0]    coef_wr_idx_reg;

   assign cmd_shift = {cmd_reg[CMD_W-2:0], mosi_sync};
   assign idx_shift = {idx_reg[IDX_W-2:0], mosi_sync};

   // Channel 0 sits in the LSBs of the holding register but leaves the wire first.
   for (genvar gi = 0; gi < N_CH; gi++) begin : g_chan
      assign hold_msb_first[(N_CH-1-gi)*SAMPLE_W +: SAMPLE_W] = hold_reg[gi*SAMPLE_W +: SAMPLE_W];
   end

   for (genvar gi = 0; gi < N_COEF; gi++) begin : g_coef
      logic [COEF_W-1:0] val_reg;
      always_ff @(posedge clk_48) begin
         if (reset)                                   val_reg <= '0;
         else if (coef_we && idx_reg == IDX_W'(gi))   val_reg <= rx_next;
      end
      assign coef_out[gi*COEF_W +: COEF_W] = val_reg;
   end

   // Out-of-range indices match no slot and read back as zero.
   always_comb begin
      coef_rd = '0;
      for (int i = 0; i < N_COEF; i++)
         if (idx_shift == IDX_W'(i)) coef_rd = coef_out[i*COEF_W +: COEF_W];
   end

   always_comb begin
      case (cmd_reg)
         CMD_READ_SAMPLES: tx_last = CNT_W'(SMP_W - 1);
         CMD_READ_COEF:    tx_last = CNT_W'(COEF_W - 1);
         default:          tx_last = CNT_W'(7);
      endcase
   end

   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      cmd_next   = cmd_reg;
      idx_next   = idx_reg;
      rx_next    = rx_reg;
      tx_next    = tx_reg;
      miso_next  = miso_reg;
      fresh_next = fresh_reg;
      err_inc    = 1'b0;
      coef_we    = 1'b0;
      case (state_reg)
         IDLE: begin
            miso_next = 1'b0;
            if (cs_fall) begin
               state_next = CMD;
               cnt_next   = '0;
            end
         end
         CMD: if (sclk_rise) begin
            cmd_next = cmd_shift;
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(CMD_W - 1)) begin
               cnt_next = '0;
               case (cmd_shift)
                  CMD_READ_SAMPLES: begin
                     state_next = TX;
                     tx_next    = TX_W'(hold_msb_first) << (TX_W - SMP_W);
                     fresh_next = 1'b0;
                  end
                  CMD_STATUS: begin
                     state_next = TX;
                     tx_next    = TX_W'({fresh_reg, err_reg}) << (TX_W - 8);
                  end
                  CMD_WRITE_COEF, CMD_READ_COEF: state_next = INDEX;
                  default: begin
                     state_next = ERR;
                     err_inc    = 1'b1;
                  end
               endcase
            end
         end
         INDEX: if (sclk_rise) begin
            idx_next = idx_shift;
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(IDX_W - 1)) begin
               cnt_next = '0;
               if (cmd_reg == CMD_WRITE_COEF) begin
                  state_next = RX;
               end else begin
                  state_next = TX;
                  tx_next    = TX_W'(coef_rd) << (TX_W - COEF_W);
                  err_inc    = (idx_shift >= IDX_W'(N_COEF));
               end
            end
         end
         RX: if (sclk_rise) begin
            rx_next  = {rx_reg[COEF_W-2:0], mosi_sync};
            cnt_next = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_W'(COEF_W - 1)) begin
               state_next = DONE;
               coef_we    = (idx_reg < IDX_W'(N_COEF));
               err_inc    = (idx_reg >= IDX_W'(N_COEF));
            end
         end
         TX: begin
            if (sclk_fall) begin
               miso_next = tx_reg[TX_W-1];
               tx_next   = tx_reg << 1;
            end
            if (sclk_rise) begin
               cnt_next = cnt_reg + CNT_W'(1);
               if (cnt_reg == tx_last) begin
                  state_next = DONE;
                  miso_next  = 1'b0;
               end
            end
         end
         default: miso_next = 1'b0;
      endcase
      // Deselect wins over everything; leaving an unfinished frame counts as an error.
      if (cs_sync) begin
         state_next = IDLE;
         miso_next  = 1'b0;
         coef_we    = 1'b0;
         if (cs_rise && (state_reg == CMD || state_reg == INDEX ||
                         state_reg == RX  || state_reg == TX))
            err_inc = 1'b1;
      end
      if (sample_valid) fresh_next = 1'b1;
   end

   always_ff @(posedge clk_48) begin
      if (reset) begin
         state_reg       <= IDLE;
         cnt_reg         <= '0;
         cmd_reg         <= '0;
         idx_reg         <= '0;
         rx_reg          <= '0;
         tx_reg          <= '0;
         miso_reg        <= 1'b0;
         hold_reg        <= '0;
         fresh_reg       <= 1'b0;
         err_reg         <= '0;
         coef_wr_reg     <= 1'b0;
         coef_wr_idx_reg <= '0;
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         cmd_reg     <= cmd_next;
         idx_reg     <= idx_next;
         rx_reg      <= rx_next;
         tx_reg      <= tx_next;
         miso_reg    <= miso_next;
         fresh_reg   <= fresh_next;
         coef_wr_reg <= coef_we;
         if (sample_valid)              hold_reg        <= samples_in;
         if (err_inc && err_reg != '1)  err_reg         <= err_reg + ERR_W'(1);
         if (coef_we)                   coef_wr_idx_reg <= idx_reg[WI_W-1:0];
      end
   end

   assign spi.MISO    = miso_reg;
   assign coef_wr     = coef_wr_reg;
   assign coef_wr_idx = coef_wr_idx_reg;

endmodule

// File: tb/tb_spi_ctrl_port.sv
// Directed bench for spi_ctrl_port: a pin-level monitor checks every SPI frame and
// every coef_wr pulse against expectations queued by the stimulus process.
module tb_spi_ctrl_port;
   import spi_ctrl_pkg::*;

   typedef struct {
      int           tag;
      int           nbits;
      logic [127:0] bits;
   } frame_t;

   typedef struct {
      int          idx;
      logic [63:0] val;
   } wr_t;

   logic         clk_48 = 1'b0;
   logic         reset;
   logic         sample_valid;
   logic [31:0]  samples_in;
   logic [639:0] coef_out;
   logic         coef_wr;
   logic [3:0]   coef_wr_idx;
   logic [639:0] coef_model;

   int total = 0;
   int bad   = 0;
   int tag_n = 0;
   frame_t frame_q[$];
   wr_t    wr_q[$];

   spi_ctrl_port_if spi();

   spi_ctrl_port dut (
      .clk_48(clk_48), .reset(reset), .spi(spi),
      .sample_valid(sample_valid), .samples_in(samples_in),
      .coef_out(coef_out), .coef_wr(coef_wr), .coef_wr_idx(coef_wr_idx));

   always #10 clk_48 = ~clk_48;

   // Frame monitor: MISO as seen by the host at each SCLK rise while CS is low.
   initial begin
      forever begin
         logic [127:0] got;
         int           nb;
         frame_t       e;
         @(negedge spi.CS);
         got = '0;
         nb  = 0;
         forever begin
            @(posedge spi.SCLK or posedge spi.CS);
            if (spi.CS) break;
            got = {got[126:0], spi.MISO};
            nb++;
         end
         total++;
         if (frame_q.size() == 0) begin
            bad++;
            $display("FAIL frame_unexpected: got %0d bits %h, no frame queued", nb, got);
         end else begin
            e = frame_q.pop_front();
            if (nb != e.nbits || got != e.bits) begin
               bad++;
               $display("FAIL frame%0d: got %0d bits %h, want %0d bits %h",
                        e.tag, nb, got, e.nbits, e.bits);
            end else
               $display("frame%0d ok: %0d bits %h", e.tag, nb, got);
         end
      end
   end

   // Coefficient-write monitor: every coef_wr pulse must match a queued write.
   always @(negedge clk_48) begin
      if (!reset && coef_wr) begin
         wr_t w;
         total++;
         if (wr_q.size() == 0) begin
            bad++;
            $display("FAIL coef_wr_unexpected: idx %0d", coef_wr_idx);
         end else begin
            w = wr_q.pop_front();
            if (int'(coef_wr_idx) != w.idx || coef_out[w.idx*64 +: 64] != w.val) begin
               bad++;
               $display("FAIL coef_wr: got idx %0d val %h, want idx %0d val %h",
                        coef_wr_idx, coef_out[int'(coef_wr_idx)*64 +: 64], w.idx, w.val);
            end else
               $display("coef_wr ok: idx %0d val %h", w.idx, w.val);
         end
      end
   end

   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [639:0] got, input logic [639:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %h, want %h", name, got[127:0], want[127:0]);
      end else
         $display("%s ok", name);
   endtask

   task automatic spi_txn(input logic [127:0] tx, input int nbits);
      @(negedge clk_48);
      spi.CS = 1'b0;
      repeat (4) @(negedge clk_48);
      for (int i = nbits - 1; i >= 0; i--) begin
         spi.MOSI = tx[i];
         repeat (4) @(negedge clk_48);
         spi.SCLK = 1'b1;
         repeat (4) @(negedge clk_48);
         spi.SCLK = 1'b0;
      end
      repeat (4) @(negedge clk_48);
      spi.CS   = 1'b1;
      spi.MOSI = 1'b0;
      repeat (8) @(negedge clk_48);
   endtask

   task automatic run(input logic [127:0] tx, input int nbits, input logic [127:0] exp_bits);
      frame_t f;
      f.tag   = tag_n++;
      f.nbits = nbits;
      f.bits  = exp_bits;
      frame_q.push_back(f);
      spi_txn(tx, nbits);
   endtask

   task automatic load_samples(input logic [31:0] s);
      @(negedge clk_48);
      samples_in   = s;
      sample_valid = 1'b1;
      @(negedge clk_48);
      sample_valid = 1'b0;
   endtask

   task automatic status(input logic [7:0] want);
      run({8'h04, 16'h0000}, 24, {8'h00, want, 8'h00});
   endtask

   initial begin
      wr_t w;
      reset = 1'b1; sample_valid = 1'b0; samples_in = '0;
      spi.CS = 1'b1; spi.SCLK = 1'b0; spi.MOSI = 1'b0;
      coef_model = '0;
      repeat (4) @(negedge clk_48);
      reset = 1'b0;
      @(negedge clk_48);
      check("reset_miso", 640'(spi.MISO), 640'(0));
      check("reset_coef_out", coef_out, '0);
      check("reset_coef_wr", 640'(coef_wr), 640'(0));
      check("reset_coef_wr_idx", 640'(coef_wr_idx), 640'(0));

      load_samples({16'hFEDC, 16'h1234});
      run({8'h01, 32'h0}, 40, {8'h00, 32'h1234_FEDC});
      status(8'h00);

      w.idx = 3; w.val = 64'h0123_4567_89AB_CDEF;
      wr_q.push_back(w);
      coef_model[3*64 +: 64] = 64'h0123_4567_89AB_CDEF;
      run({8'h02, 8'h03, 64'h0123_4567_89AB_CDEF}, 80, '0);
      check("coef_after_write3", coef_out, coef_model);
      run({8'h03, 8'h03, 64'h0}, 80, {16'h0, 64'h0123_4567_89AB_CDEF});

      // Abort a readback while MISO carries a 1; the pin must drop once CS is high.
      run({8'h03, 8'h03, 23'h0}, 39, {16'h0, 23'h091A2});
      check("miso_low_after_abort", 640'(spi.MISO), 640'(0));

      run({8'h02, 8'h0C, 64'hDEAD_BEEF_CAFE_F00D}, 80, '0);
      check("coef_after_bad_write", coef_out, coef_model);
      status(8'h02);
      run({8'h03, 8'h0C, 64'h0}, 80, '0);
      run({8'h7F, 16'hFFFF}, 24, '0);
      status(8'h04);

      run({8'h02, 8'h05, 40'hAA_5555_AAAA}, 56, '0);
      check("coef_after_partial_write", coef_out, coef_model);
      status(8'h05);
      run({8'h01, 32'h0}, 40, {8'h00, 32'h1234_FEDC});

      fork
         run({8'h01, 32'h0}, 40, {8'h00, 32'h1234_FEDC});
         begin
            repeat (150) @(negedge clk_48);
            samples_in   = {16'hFFFF, 16'h0001};
            sample_valid = 1'b1;
            @(negedge clk_48);
            sample_valid = 1'b0;
         end
      join
      status(8'h85);
      run({8'h01, 32'h0}, 40, {8'h00, 32'h0001_FFFF});
      status(8'h05);

      // Empty frames: each CS pulse with no clocks is an error; the counter must stick at 127.
      for (int i = 0; i < 125; i++) run('0, 0, '0);
      status(8'h7F);

      @(negedge clk_48);
      reset = 1'b1;
      repeat (3) @(negedge clk_48);
      reset = 1'b0;
      coef_model = '0;
      @(negedge clk_48);
      check("coef_after_reset", coef_out, coef_model);
      status(8'h00);
      run({8'h01, 32'h0}, 40, {8'h00, 32'h0});

      repeat (20) @(negedge clk_48);
      check("frames_outstanding", 640'(frame_q.size()), 640'(0));
      check("writes_outstanding", 640'(wr_q.size()), 640'(0));
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
